// File: rtl/mem_port_arbiter_pkg.sv
// Shared state and owner encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between instruction fetch and data access,
// one outstanding transaction at a time, data requests winning over fetches.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_valid,
    output logic                inst_stallreq,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_valid,
    output logic                data_stallreq,
    input  logic                flush,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t state_reg, state_next;
    arb_owner_t owner_reg, owner_next;
    logic       discard_reg, discard_next;
    logic       grant_data, grant_inst;
    logic       done;
    logic       inst_valid_next, data_valid_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ARB_IDLE;
            owner_reg   <= ARB_OWN_INST;
            discard_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            discard_reg <= discard_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        discard_next    = discard_reg;
        grant_data      = 1'b0;
        grant_inst      = 1'b0;
        done            = 1'b0;
        inst_valid_next = 1'b0;
        data_valid_next = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                discard_next = 1'b0;
                if (data_req) begin
                    grant_data = 1'b1;
                    owner_next = ARB_OWN_DATA;
                    state_next = ARB_ADDR;
                end else if (inst_req && !flush) begin
                    grant_inst = 1'b1;
                    owner_next = ARB_OWN_INST;
                    state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (flush && owner_reg == ARB_OWN_INST)
                    discard_next = 1'b1;
                if (mem_addr_ok)
                    state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (flush && owner_reg == ARB_OWN_INST)
                    discard_next = 1'b1;
                if (mem_data_ok) begin
                    done         = 1'b1;
                    state_next   = ARB_IDLE;
                    discard_next = 1'b0;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        // A flush arriving in the same cycle as the response still kills the fetch.
        if (done && owner_reg == ARB_OWN_INST)
            inst_valid_next = !(discard_reg || flush);
        if (done && owner_reg == ARB_OWN_DATA)
            data_valid_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (grant_data) begin
                mem_wr    <= data_wr;
                mem_wstrb <= data_wen;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end else if (grant_inst) begin
                mem_wr    <= 1'b0;
                mem_wstrb <= {STRB_W{1'b0}};
                mem_addr  <= inst_addr;
                mem_wdata <= '0;
            end
            if (done && owner_reg == ARB_OWN_INST)
                inst_rdata <= mem_rdata;
            if (done && owner_reg == ARB_OWN_DATA)
                data_rdata <= mem_rdata;
            inst_valid <= inst_valid_next;
            data_valid <= data_valid_next;
        end
    end

    assign mem_req       = (state_reg == ARB_ADDR);
    assign inst_stallreq = inst_req & ~inst_valid;
    assign data_stallreq = data_req & ~data_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_stallreq;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        data_stallreq;
    logic        flush;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_valid(inst_valid), .inst_stallreq(inst_stallreq),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_valid(data_valid), .data_stallreq(data_stallreq),
        .flush(flush),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        flush = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_data_valid", data_valid, 0);
        rst = 1'b0;
        tick();

        // 1: single fetch at minimum latency
        inst_req = 1; inst_addr = 32'hBFC00000;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'hBFC00000);
        chk("t1_mem_wr", mem_wr, 0);
        chk("t1_stall", inst_stallreq, 1);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0;
        chk("t1_req_drop", mem_req, 0);
        chk("t1_valid_early", inst_valid, 0);
        mem_data_ok = 1; mem_rdata = 32'h3C080001;
        tick();
        mem_data_ok = 0;
        chk("t1_valid", inst_valid, 1);
        chk("t1_rdata", inst_rdata, 32'h3C080001);
        chk("t1_stall_off", inst_stallreq, 0);
        inst_req = 0;
        tick();
        chk("t1_valid_pulse", inst_valid, 0);
        chk("t1_idle", mem_req, 0);

        // 2: simultaneous requests, data wins
        inst_req = 1; inst_addr = 32'hBFC00000;
        data_req = 1; data_wr = 0; data_addr = 32'h80000010;
        tick();
        chk("t2_first_addr", mem_addr, 32'h80000010);
        chk("t2_inst_stall", inst_stallreq, 1);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_data_ok = 0;
        chk("t2_data_valid", data_valid, 1);
        chk("t2_data_rdata", data_rdata, 32'hDEADBEEF);
        chk("t2_inst_not_yet", inst_valid, 0);
        data_req = 0;
        tick();
        chk("t2_inst_req", mem_req, 1);
        chk("t2_inst_addr", mem_addr, 32'hBFC00000);
        chk("t2_data_pulse", data_valid, 0);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
        tick();
        mem_data_ok = 0;
        chk("t2_inst_valid", inst_valid, 1);
        chk("t2_inst_rdata", inst_rdata, 32'h11112222);
        inst_req = 0;
        tick();

        // 3: store with addr_ok held off; requester fields change after grant
        data_req = 1; data_wr = 1; data_wen = 4'b0011;
        data_wdata = 32'h1234ABCD; data_addr = 32'h80000020;
        tick();
        data_addr = 32'hFFFFFFF0; data_wdata = 32'h0; data_wen = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_req_%0d", i), mem_req, 1);
            chk($sformatf("t3_addr_%0d", i), mem_addr, 32'h80000020);
            chk($sformatf("t3_strb_%0d", i), mem_wstrb, 4'b0011);
            chk($sformatf("t3_wdata_%0d", i), mem_wdata, 32'h1234ABCD);
            tick();
        end
        chk("t3_req_still", mem_req, 1);
        chk("t3_mem_wr", mem_wr, 1);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        chk("t3_no_early_valid", data_valid, 0);
        tick();
        mem_data_ok = 0;
        chk("t3_valid", data_valid, 1);
        data_req = 0; data_wr = 0; data_wen = 0;
        tick();
        chk("t3_valid_pulse", data_valid, 0);

        // 4: flush while fetch waits for data
        inst_req = 1; inst_addr = 32'hBFC00100;
        tick();
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; flush = 1;
        tick();
        flush = 0; mem_data_ok = 1; mem_rdata = 32'hAAAAAAAA;
        tick();
        mem_data_ok = 0; inst_addr = 32'hBFC00104;
        chk("t4_suppressed", inst_valid, 0);
        chk("t4_idle", mem_req, 0);
        chk("t4_stall", inst_stallreq, 1);
        tick();
        chk("t4_refetch_req", mem_req, 1);
        chk("t4_refetch_addr", mem_addr, 32'hBFC00104);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h55556666;
        tick();
        mem_data_ok = 0;
        chk("t4_valid", inst_valid, 1);
        chk("t4_rdata", inst_rdata, 32'h55556666);
        inst_req = 0;
        tick();

        // 5: asynchronous reset in WAIT, then a stray response
        data_req = 1; data_wr = 0; data_addr = 32'h80000030;
        tick();
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0;
        chk("t5_pre_addr", mem_addr, 32'h80000030);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_drdata", data_rdata, 0);
        chk("t5_rst_irdata", inst_rdata, 0);
        data_req = 0;
        tick();
        rst = 1'b0;
        mem_data_ok = 1; mem_rdata = 32'h99999999;
        tick();
        mem_data_ok = 0;
        chk("t5_stray_dvalid", data_valid, 0);
        chk("t5_stray_ivalid", inst_valid, 0);
        chk("t5_stray_rdata", data_rdata, 0);
        tick();

        // 6: back-to-back loads, memory always ready
        data_req = 1; data_wr = 0; data_addr = 32'h80000040;
        inst_req = 1; inst_addr = 32'hBFC00200;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("t6_dvalid_c%0d", c), data_valid, (c % 3 == 0) ? 1 : 0);
            chk($sformatf("t6_istall_c%0d", c), inst_stallreq, 1);
            chk($sformatf("t6_mreq_c%0d", c), mem_req, (c % 3 == 1) ? 1 : 0);
        end
        chk("t6_addr", mem_addr, 32'h80000040);
        chk("t6_rdata", data_rdata, 32'hCAFEF00D);
        data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        tick();
        chk("t6_end_idle", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
